// File: rtl/dct_nios_debug_host_scan.sv
// dct_nios_debug_host_scan: host-side virtual-JTAG scan engine running one IR update and one DR scan per command
module dct_nios_debug_host_scan #(
    parameter int TCK_HALF = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int CW = $clog2(DR_WIDTH + 1);
    localparam int HW = TCK_HALF > 1 ? $clog2(TCK_HALF) : 1;

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;

    state_t              state, state_nx;
    logic [HW-1:0]       hc;
    logic [CW-1:0]       cnt;
    logic [DR_WIDTH-1:0] shift, capture;
    logic                run, wrap, rise, fall;

    assign run        = state inside {UIR, CDR, SDR, UDR};
    assign wrap       = run && hc == HW'(TCK_HALF - 1);
    assign rise       = wrap && !vji_tck;
    assign fall       = wrap && vji_tck;
    assign cmd_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign rsp_valid  = state == RSP;
    assign rsp_dr     = capture;
    assign vji_uir    = state == UIR;
    assign vji_cdr    = state == CDR;
    assign vji_sdr    = state == SDR;
    assign vji_udr    = state == UDR;
    assign vji_rti    = state == IDLE || state == RSP;

    // next state: each scan state ends on the fall cycle closing its slot
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? UIR : IDLE;
            UIR:     state_nx = fall ? CDR : UIR;
            CDR:     state_nx = fall ? SDR : CDR;
            SDR:     state_nx = fall && cnt == CW'(DR_WIDTH) ? UDR : SDR;
            UDR:     state_nx = fall ? RSP : UDR;
            RSP:     state_nx = rsp_ready ? IDLE : RSP;
            default: state_nx = IDLE;
        endcase
    end

    // state register and tck divider; tck parked low outside the scan states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hc      <= '0;
            vji_tck <= 1'b0;
        end else begin
            state   <= state_nx;
            hc      <= (wrap || !run) ? '0 : hc + 1'b1;
            vji_tck <= run && (vji_tck ^ wrap);
        end
    end

    // scan datapath: tdi changes on fall cycles, tdo and ir_out sampled on rise cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_ir_in  <= '0;
            vji_tdi    <= 1'b0;
            shift      <= '0;
            capture    <= '0;
            cnt        <= '0;
            rsp_ir_out <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                vji_ir_in <= cmd_ir;
                shift     <= cmd_dr;
                cnt       <= '0;
            end
            if (state == UIR && fall)
                vji_tdi <= shift[0];
            if (state == CDR && rise)
                rsp_ir_out <= vji_ir_out;
            if (state == SDR && rise) begin
                capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
                cnt     <= cnt + 1'b1;
            end
            if (state == SDR && fall) begin
                shift   <= shift >> 1;
                vji_tdi <= shift[1];
            end
        end
    end
endmodule

// File: tb/tb_dct_nios_debug_host_scan.sv
// tb_dct_nios_debug_host_scan: scoreboard bench with a shift-register slave model
module tb_dct_nios_debug_host_scan;
    localparam int DW  = 38;
    localparam int IW  = 2;
    localparam int LAT = 165;

    typedef struct {
        logic [DW-1:0] dr;
        logic [IW-1:0] ir;
        logic [DW-1:0] sr_after;
        logic [IW-1:0] ir_in;
        int            acc_cyc;
        int            rises0;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [IW-1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [DW-1:0] cmd_dr, rsp_dr;
    logic          vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic [DW-1:0] sr, load_val, model_sr;
    logic          load = 1'b0;
    exp_t          q[$];
    int            cyc = 0, sdr_rises = 0, checks = 0, errors = 0;
    int            valid_cycles = 0, last_rsp_cyc = -10, first_cyc = 0;
    bit            seen = 0;

    dct_nios_debug_host_scan dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .busy(busy), .vji_tck(vji_tck),
        .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // slave DR: presents sr[0] on tdo and shifts tdi in on each tck rise during SDR
    always @(posedge vji_tck or posedge load)
        if (load) sr <= load_val;
        else if (vji_sdr) sr <= {vji_tdi, sr[DW-1:1]};

    assign vji_tdo = sr[0];

    always @(posedge vji_tck) if (vji_sdr) sdr_rises++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk(name, {cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
                   vji_udr, vji_rti, vji_ir_in, rsp_ir_out, rsp_dr}, {10'b10_0000_0001, 42'd0});
    endtask

    task automatic preload(input logic [DW-1:0] v);
        load_val = v;
        load = 1'b1;
        #1;
        load = 1'b0;
        model_sr = v;
    endtask

    task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                         input logic [IW-1:0] irout, input bit b2b);
        int n = 0;
        exp_t e;
        cmd_ir = ir;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
        end
        chk("accept_timeout", n < 400, 1);
        if (b2b) chk("b2b_idle_gap", cyc - last_rsp_cyc, 1);
        vji_ir_out = irout;
        e.dr = model_sr;
        e.ir = irout;
        e.sr_after = dr;
        e.ir_in = ir;
        e.acc_cyc = cyc;
        e.rises0 = sdr_rises;
        q.push_back(e);
        model_sr = dr;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("done_timeout", n < 3000, 1);
        rsp_ready = 1'b1;
        tick();
    endtask

    function automatic logic [DW-1:0] rnd_dr();
        logic [63:0] t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // monitor: strobe exclusivity every cycle, scoreboard pop on each response handshake
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) seen = 0;
        else begin
            chk("strobe_onehot", $countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 1);
            if (rsp_valid) begin
                valid_cycles++;
                if (!seen) begin
                    seen = 1;
                    first_cyc = cyc;
                    chk("rsp_expected", q.size() != 0, 1);
                end
                if (rsp_ready) begin
                    seen = 0;
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("rsp_dr", rsp_dr, e.dr);
                        chk("rsp_ir_out", rsp_ir_out, e.ir);
                        chk("slave_sr_after", sr, e.sr_after);
                        chk("vji_ir_in", vji_ir_in, e.ir_in);
                        chk("latency", first_cyc - e.acc_cyc, LAT);
                        chk("sdr_rises", sdr_rises - e.rises0, DW);
                        last_rsp_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int n, base, vc;
        logic [DW-1:0] exp_dr;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cmd_ir = '0;
        cmd_dr = '0;
        vji_ir_out = '0;
        load_val = '0;
        model_sr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_hold");
        reset_n = 1'b1;
        #1;
        check_reset("reset_release");
        tick();

        preload('0);
        issue(2'b10, 38'h2A_5555_AAAA, 2'b11, 0);
        wait_done(0);

        preload(38'h3F_0000_0001);
        issue(2'b01, rnd_dr(), 2'b01, 0);
        wait_done(0);

        rsp_ready = 1'b1;
        issue(2'b11, rnd_dr(), 2'b10, 0);
        issue(2'b00, rnd_dr(), 2'b01, 1);
        issue(2'b10, rnd_dr(), 2'b00, 1);
        wait_done(0);

        rsp_ready = 1'b0;
        exp_dr = model_sr;
        issue(2'b01, rnd_dr(), 2'b11, 0);
        n = 0;
        while (!rsp_valid && n < 400) begin
            tick();
            n++;
        end
        chk("bp_valid_timeout", n < 400, 1);
        repeat (20) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rsp_dr", rsp_dr, exp_dr);
            chk("bp_tck", vji_tck, 0);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_next", cmd_ready, 1);

        repeat (8) begin
            issue(2'($urandom()), rnd_dr(), 2'($urandom()), 0);
            wait_done(1);
        end

        base = sdr_rises;
        issue(2'b11, rnd_dr(), 2'b01, 0);
        n = 0;
        while (sdr_rises - base < 10 && n < 400) begin
            tick();
            n++;
        end
        chk("mid_rise_timeout", n < 400, 1);
        reset_n = 1'b0;
        #1;
        check_reset("mid_reset");
        q.delete();
        vc = valid_cycles;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (200) tick();
        chk("no_rsp_after_abort", valid_cycles, vc);
        preload(rnd_dr());
        issue(2'b10, rnd_dr(), 2'b10, 0);
        wait_done(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dct_nios_debug_host_scan.md
Name: dct_nios_debug_host_scan

Overview:
- Host-side scan engine that drives the Nios II debug slave's virtual-JTAG interface (tck, tdi, ir_in, cdr/sdr/udr/uir, rti) and receives tdo/ir_out.
- Sits between a system-clock command port (testbench or on-chip debug bridge) and the debug slave's TCK-side logic.
- For each command it runs one IR update followed by one full DR scan, and returns the shifted-out DR contents.
- tck is generated as a registered, divided copy of clk.

Parameters:
- TCK_HALF, 2: clk cycles per tck half-period; legal values are 1 or more.
- DR_WIDTH, 38: DR scan length in bits; matches the slave's sr/jdo width.
- IR_WIDTH, 2: virtual IR width.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_dr  in  DR_WIDTH  DR value to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_dr  out  DR_WIDTH  captured tdo bits; first bit shifted out lands in bit 0.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR.
- busy  out  1  state is not IDLE.
- vji_tck  out  1  generated tck.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  IR value presented to the slave.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.
- vji_rti  out  1  run-test-idle indication.

Behaviour:
- Reset state (asynchronous, reset_n=0): state IDLE, all outputs 0 except cmd_ready=1 and vji_rti=1; rsp_dr and rsp_ir_out are 0.
- A reset asserted mid-scan aborts at once with no response. The slave sees tck=0, all strobes 0 and rti=1.
- tck generation:
  - A half-period counter counts 0..TCK_HALF-1 and toggles vji_tck on wrap.
  - tck runs only outside IDLE and RSP, and is held 0 in those two states.
  - The "rise" cycle is the clk cycle in which vji_tck is driven 0->1; the "fall" cycle is 1->0.
- One tck period ("slot") is 2*TCK_HALF clk cycles, starting with tck low.
- FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RSP -> IDLE.
- IDLE:
  - cmd_ready=1, rti=1.
  - On cmd_valid, latch cmd_ir into vji_ir_in and cmd_dr into the shift register, clear the bit counter, go to UIR.
  - vji_ir_in holds its value until the next command.
- UIR: vji_uir=1 for exactly 1 slot, then CDR.
- CDR:
  - vji_cdr=1 for 1 slot.
  - Sample vji_ir_out into rsp_ir_out on the rise cycle.
  - Drive vji_tdi = shift[0] at slot start.
  - Then SDR.
- SDR: vji_sdr=1 for exactly DR_WIDTH slots.
  - On each rise cycle: capture <= {vji_tdo, capture[DR_WIDTH-1:1]}; counter++.
  - On each fall cycle: shift >>= 1 and vji_tdi = next bit.
  - After the DR_WIDTH-th rise, finish the slot, then go to UDR.
  - The bit counter has ceil(log2(DR_WIDTH+1)) bits and never wraps.
- UDR: vji_udr=1 for 1 slot, then RSP.
- RSP:
  - rsp_valid=1 and rsp_dr=capture; tck=0, rti=1.
  - Hold until rsp_ready=1, then return to IDLE in the next cycle.
  - If rsp_ready is already high on entry, rsp_valid is high for exactly 1 cycle.
- Exactly one of uir/cdr/sdr/udr/rti is high in any cycle; RSP counts as rti.
- Latency, cmd accept to rsp_valid: (DR_WIDTH+3) × 2 × TCK_HALF + 1 clk cycles. With defaults this is 165 cycles.
- cmd_valid while busy: ignored, because cmd_ready=0; no queuing.
- TCK_HALF=1: tck toggles every clk cycle; rise and fall cycles alternate; functionally identical otherwise.

Test Plan:
- Reset value check: hold reset_n=0 for 3 cycles and release -> cmd_ready=1, vji_rti=1, vji_tck=0, busy=0, every strobe 0.
- Single scan with loop-back model: cmd_ir=2'b10, cmd_dr=38'h2A_5555_AAAA, slave model returns tdo equal to tdi delayed 38 bits, initially 0 -> the following hold:
  - rsp_dr=0;
  - rsp_valid rises 165 cycles after the accept;
  - exactly 38 tck rising edges occur with vji_sdr=1;
  - vji_ir_in=2'b10.
- Slave-shift model: model preloads sr=38'h3F_0000_0001 and shifts sr={tdi,sr[37:1]} on each rise with sdr=1 -> rsp_dr=38'h3F_0000_0001; the model's sr equals cmd_dr after UDR.
- ir_out capture and back-to-back commands: vji_ir_out=2'b01 during CDR gives rsp_ir_out=2'b01. Back-to-back with rsp_ready held high: IDLE lasts 1 cycle between scans and cmd_ready pulses once per scan.
- Response backpressure: rsp_ready=0 for 20 cycles -> rsp_valid stays high, rsp_dr is stable, vji_tck stays 0 and busy=1; rsp_ready=1 -> IDLE on the next cycle.
- Reset mid-SDR: assert reset_n=0 after the 10th tck rise -> all outputs return to reset values within the same cycle and no rsp_valid is produced; a following fresh command completes normally.
